// File: rtl/wb_stream_reader.sv
// Stream-to-memory DMA engine. Buffers a valid/ready word stream in a small
// FIFO and writes it to memory as Wishbone incrementing bursts. Configured
// through a Wishbone slave register file; raises a level interrupt when the
// programmed buffer is filled or a bus error aborts the job.
module wb_stream_reader #(
  parameter int unsigned FIFO_AW       = 5,
  parameter int unsigned MAX_BURST_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  // Memory write master
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  // Incoming stream
  input  logic [31:0] stream_s_data_i,
  input  logic        stream_s_valid_i,
  output logic        stream_s_ready_o,
  output logic        stream_s_irq_o,
  // Config slave
  input  logic [4:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned CntW  = FIFO_AW + 1;
  localparam logic [FIFO_AW-1:0] PtrOne  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0]    CntOne  = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0]    FullCnt = CntW'(Depth);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e state_q, state_d;

  // Config and job state
  logic [31:0] start_addr_q, buf_size_q, burst_size_q;
  logic        busy_q, irq_q, err_q;
  logic [29:0] remaining_q, accepted_q;
  logic [31:0] addr_q;
  logic [31:0] burst_len_q, beat_q;

  // FIFO
  logic [31:0]        fifo_mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    fifo_cnt_q;

  logic        wbs_req, wbs_wr;
  logic [2:0]  reg_sel;
  logic [31:0] rdata;
  logic        start_req, irq_clr;
  logic [29:0] total_words;
  logic [31:0] eff_burst, burst_len;
  logic        push, beat_ack, bus_err, last_beat, enter_burst;

  logic unused_inputs;
  assign unused_inputs = ^{wbm_dat_i, wbm_rty_i, wbs_sel_i, wbs_cti_i, wbs_bte_i,
                           wbs_adr_i[1:0]};

  assign wbs_req     = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign wbs_wr      = wbs_req && wbs_we_i;
  assign reg_sel     = wbs_adr_i[4:2];
  assign start_req   = wbs_wr && (reg_sel == 3'd0) && wbs_dat_i[0] && !busy_q;
  assign irq_clr     = wbs_wr && (reg_sel == 3'd0) && wbs_dat_i[1];
  assign total_words = buf_size_q[31:2];
  assign wbs_err_o   = 1'b0;
  assign wbs_rty_o   = 1'b0;

  assign stream_s_ready_o = busy_q && (fifo_cnt_q != FullCnt) && (accepted_q < total_words);
  assign push             = stream_s_valid_i && stream_s_ready_o;
  assign stream_s_irq_o   = irq_q;
  assign enter_burst      = (state_q == StIdle) && (state_d == StBurst);

  // Clamp the programmed burst length and trim it to the words still owed
  always_comb begin
    if (burst_size_q == 32'd0) begin
      eff_burst = 32'd1;
    end else if (burst_size_q > MAX_BURST_LEN) begin
      eff_burst = MAX_BURST_LEN;
    end else begin
      eff_burst = burst_size_q;
    end
    burst_len = ({2'b00, remaining_q} < eff_burst) ? {2'b00, remaining_q} : eff_burst;
  end

  // Config register read mux
  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0:    rdata = {29'b0, err_q, irq_q, busy_q};
      3'd1:    rdata = start_addr_q;
      3'd2:    rdata = buf_size_q;
      3'd3:    rdata = burst_size_q;
      default: rdata = '0;
    endcase
  end

  // Master FSM next state and bus outputs
  always_comb begin
    state_d   = state_q;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    wbm_we_o  = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_cti_o = '0;
    wbm_bte_o = '0;
    beat_ack  = 1'b0;
    bus_err   = 1'b0;
    last_beat = (beat_q == burst_len_q - 32'd1);
    unique case (state_q)
      StIdle: begin
        if (busy_q && (burst_len != 32'd0) && (32'(fifo_cnt_q) >= burst_len)) begin
          state_d = StBurst;
        end
      end
      StBurst: begin
        wbm_adr_o = addr_q;
        wbm_dat_o = fifo_mem[rd_ptr_q];
        wbm_sel_o = 4'hf;
        wbm_we_o  = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_cti_o = last_beat ? 3'b111 : 3'b010;
        if (wbm_err_i) begin
          // Error aborts the job; the erroring beat is not counted
          bus_err = 1'b1;
          state_d = StIdle;
        end else if (wbm_ack_i) begin
          beat_ack = 1'b1;
          if (last_beat) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Config slave, job counters and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      start_addr_q <= '0;
      buf_size_q   <= '0;
      burst_size_q <= '0;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
      err_q        <= 1'b0;
      remaining_q  <= '0;
      accepted_q   <= '0;
      addr_q       <= '0;
      burst_len_q  <= '0;
      beat_q       <= '0;
    end else begin
      wbs_ack_o <= wbs_req;
      if (wbs_req) wbs_dat_o <= rdata;
      if (wbs_wr && !busy_q) begin
        case (reg_sel)
          3'd1:    start_addr_q <= wbs_dat_i;
          3'd2:    buf_size_q   <= wbs_dat_i;
          3'd3:    burst_size_q <= wbs_dat_i;
          default: ;
        endcase
      end
      // Clear first so any same-cycle set below wins
      if (irq_clr) irq_q <= 1'b0;
      if (start_req) begin
        err_q <= 1'b0;
        if (total_words == 30'd0) begin
          irq_q <= 1'b1;
        end else begin
          busy_q      <= 1'b1;
          remaining_q <= total_words;
          addr_q      <= start_addr_q;
          accepted_q  <= '0;
        end
      end
      if (push) accepted_q <= accepted_q + 30'd1;
      if (enter_burst) begin
        burst_len_q <= burst_len;
        beat_q      <= '0;
      end
      if (beat_ack) begin
        addr_q      <= addr_q + 32'd4;
        remaining_q <= remaining_q - 30'd1;
        beat_q      <= beat_q + 32'd1;
        if (remaining_q == 30'd1) begin
          busy_q <= 1'b0;
          irq_q  <= 1'b1;
        end
      end
      if (bus_err) begin
        err_q  <= 1'b1;
        busy_q <= 1'b0;
        irq_q  <= 1'b1;
      end
    end
  end

  // FIFO storage; no reset needed, occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= stream_s_data_i;
  end

  // FIFO pointers and occupancy; a bus error flushes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (bus_err) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push)     wr_ptr_q <= wr_ptr_q + PtrOne;
      if (beat_ack) rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({push, beat_ack})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntOne;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntOne;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stream_reader.sv
// Self-checking bench for wb_stream_reader: config table, directed DMA jobs,
// randomized backpressure, bus error and reset-mid-burst sequences.
module tb_wb_stream_reader;

  localparam int MaxBurst = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [31:0] stream_s_data_i;
  logic        stream_s_valid_i, stream_s_ready_o, stream_s_irq_o;
  logic [4:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;

  wb_stream_reader #(.FIFO_AW(5), .MAX_BURST_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .stream_s_data_i(stream_s_data_i), .stream_s_valid_i(stream_s_valid_i),
    .stream_s_ready_o(stream_s_ready_o), .stream_s_irq_o(stream_s_irq_o),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] mem[logic [31:0]];
  int          ack_max = 0;
  int          wait_cnt = 0;
  int          err_at = -1;
  int          beat_idx = 0;
  bit          err_fired = 0;

  initial begin
    beat_t b;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = '0;
    wbm_rty_i = 1'b0;
    forever begin
      @(negedge clk);
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      if (!rst && wbm_cyc_o && wbm_stb_o) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          if (beat_idx == err_at) begin
            wbm_err_i = 1'b1;
            err_fired = 1'b1;
          end else begin
            wbm_ack_i = 1'b1;
            b.adr = wbm_adr_o;
            b.dat = wbm_dat_o;
            b.cti = wbm_cti_o;
            beats.push_back(b);
            mem[wbm_adr_o] = wbm_dat_o;
          end
          beat_idx++;
          wait_cnt = int'($urandom_range(ack_max, 0));
        end
      end
    end
  end

  // ---------------- stream source ----------------
  logic [31:0] tx_q[$];
  logic [31:0] exp_words[$];
  int          valid_pct = 100;
  int          n_accepted = 0;

  initial begin
    stream_s_valid_i = 1'b0;
    stream_s_data_i  = '0;
    forever begin
      @(negedge clk);
      if (tx_q.size() > 0 && int'($urandom_range(99, 0)) < valid_pct) begin
        stream_s_valid_i = 1'b1;
        stream_s_data_i  = tx_q[0];
      end else begin
        stream_s_valid_i = 1'b0;
      end
      #1;
      if (!rst && stream_s_valid_i && stream_s_ready_o) begin
        void'(tx_q.pop_front());
        n_accepted++;
      end
    end
  end

  // ---------------- config slave access ----------------
  task automatic wbs_access(input logic [4:0] adr, input logic [31:0] dat, input logic we,
                            output logic [31:0] rd);
    bit ok;
    ok = 1'b0;
    rd = '0;
    @(negedge clk);
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_we_i  = we;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin
        ok = 1'b1;
        rd = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    check("wbs_ack", {31'b0, ok}, 32'd1);
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    wbs_access(adr, dat, 1'b1, rd);
  endtask

  task automatic rd_check(input string name, input logic [4:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wbs_access(adr, 32'd0, 1'b0, rd);
    check(name, rd, exp);
  endtask

  // ---------------- job helpers and reference model ----------------
  task automatic start_job(input logic [31:0] start, input logic [31:0] size,
                           input logic [31:0] burst, input int ntx, input bit rnd, input int e_at);
    logic [31:0] w;
    tx_q.delete();
    exp_words.delete();
    beats.delete();
    beat_idx   = 0;
    wait_cnt   = 0;
    err_fired  = 1'b0;
    n_accepted = 0;
    err_at     = e_at;
    for (int i = 0; i < ntx; i++) begin
      w = rnd ? $urandom : i;
      exp_words.push_back(w);
      tx_q.push_back(w);
    end
    wr(5'h04, start);
    wr(5'h08, size);
    wr(5'h0C, burst);
    wr(5'h00, 32'd1);
  endtask

  task automatic wait_irq(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (stream_s_irq_o) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  // Expected beats: words split into chunks of min(clamped burst, remaining)
  task automatic check_job(input string tag, input logic [31:0] start, input int nwords,
                           input int burst);
    int bs, pos, len;
    bs = (burst <= 0) ? 1 : ((burst > MaxBurst) ? MaxBurst : burst);
    check({tag, " beat count"}, beats.size(), nwords);
    pos = 0;
    while (pos < nwords) begin
      len = (nwords - pos < bs) ? nwords - pos : bs;
      for (int k = 0; k < len; k++) begin
        if (pos < beats.size()) begin
          check({tag, " adr"}, beats[pos].adr, start + 32'(4 * pos));
          check({tag, " dat"}, beats[pos].dat, exp_words[pos]);
          check({tag, " cti"}, {29'b0, beats[pos].cti}, (k == len - 1) ? 32'd7 : 32'd2);
        end
        pos++;
      end
    end
  endtask

  // ---------------- config table ----------------
  typedef struct {
    logic [4:0]  adr;
    logic [31:0] wdat;
    bit          we;
    logic [31:0] exp;
  } cfg_vec_t;

  cfg_vec_t cfg_tbl[10];

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    cfg_tbl[0] = '{5'h04, 32'h40,       1'b1, 32'h0};
    cfg_tbl[1] = '{5'h08, 32'h20,       1'b1, 32'h0};
    cfg_tbl[2] = '{5'h0C, 32'h4,        1'b1, 32'h0};
    cfg_tbl[3] = '{5'h04, 32'h0,        1'b0, 32'h40};
    cfg_tbl[4] = '{5'h08, 32'h0,        1'b0, 32'h20};
    cfg_tbl[5] = '{5'h0C, 32'h0,        1'b0, 32'h4};
    cfg_tbl[6] = '{5'h00, 32'h0,        1'b0, 32'h0};
    cfg_tbl[7] = '{5'h10, 32'hdeadbeef, 1'b1, 32'h0};
    cfg_tbl[8] = '{5'h10, 32'h0,        1'b0, 32'h0};
    cfg_tbl[9] = '{5'h1C, 32'h0,        1'b0, 32'h0};

    rst       = 1'b1;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    wbs_sel_i = 4'hf;
    wbs_we_i  = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_cti_i = '0;
    wbs_bte_i = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst cyc", {31'b0, wbm_cyc_o}, 0);
    check("rst stb", {31'b0, wbm_stb_o}, 0);
    check("rst we", {31'b0, wbm_we_o}, 0);
    check("rst adr", wbm_adr_o, 0);
    check("rst sel", {28'b0, wbm_sel_o}, 0);
    check("rst cti", {29'b0, wbm_cti_o}, 0);
    check("rst ready", {31'b0, stream_s_ready_o}, 0);
    check("rst irq", {31'b0, stream_s_irq_o}, 0);
    check("rst wbs_ack", {31'b0, wbs_ack_o}, 0);
    check("rst wbs_dat", wbs_dat_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Config readback table
    foreach (cfg_tbl[i]) begin
      if (cfg_tbl[i].we) wr(cfg_tbl[i].adr, cfg_tbl[i].wdat);
      else rd_check("cfg readback", cfg_tbl[i].adr, cfg_tbl[i].exp);
    end

    // Basic DMA: two 4-beat bursts; config writes while busy are ignored
    start_job(32'h10, 32'd32, 32'd4, 8, 1'b0, -1);
    wr(5'h04, 32'habc);
    wait_irq("basic irq");
    check_job("basic", 32'h10, 8, 4);
    for (int i = 0; i < 8; i++) begin
      check("basic mem", mem.exists(32'h10 + 32'(4 * i)) ? mem[32'h10 + 32'(4 * i)] : 32'hx,
            32'(i));
    end
    rd_check("basic csr", 5'h00, 32'h2);
    rd_check("busy write ignored", 5'h04, 32'h10);
    wr(5'h00, 32'h2);
    check("irq cleared", {31'b0, stream_s_irq_o}, 0);
    rd_check("csr after clear", 5'h00, 32'h0);

    // Short final burst: 6 words of 7 offered
    start_job(32'h100, 32'd24, 32'd4, 7, 1'b0, -1);
    wait_irq("short irq");
    repeat (5) @(negedge clk);
    check_job("short", 32'h100, 6, 4);
    check("short accepted", n_accepted, 6);
    check("short leftover", tx_q.size(), 1);
    check("short ready", {31'b0, stream_s_ready_o}, 0);
    tx_q.delete();
    wr(5'h00, 32'h2);

    // Zero-sized buffer: irq without busy
    wr(5'h08, 32'd0);
    wr(5'h00, 32'd1);
    check("zero irq", {31'b0, stream_s_irq_o}, 1);
    rd_check("zero csr", 5'h00, 32'h2);
    wr(5'h00, 32'h2);

    // Backpressure: random ack delay and random valid
    ack_max   = 5;
    valid_pct = 50;
    start_job(32'h1000, 32'd128, 32'd8, 32, 1'b1, -1);
    wait_irq("bp irq");
    check_job("bp", 32'h1000, 32, 8);
    wr(5'h00, 32'h2);

    // BURST_SIZE 0 behaves as 1; oversize is clipped to the maximum
    ack_max   = 0;
    valid_pct = 100;
    start_job(32'h2000, 32'd12, 32'd0, 3, 1'b1, -1);
    wait_irq("b0 irq");
    check_job("b0", 32'h2000, 3, 0);
    wr(5'h00, 32'h2);
    start_job(32'h3000, 32'd160, 32'd100, 40, 1'b1, -1);
    wait_irq("clip irq");
    check_job("clip", 32'h3000, 40, 100);
    wr(5'h00, 32'h2);

    // Bus error on the second beat of the first burst
    start_job(32'h200, 32'd32, 32'd4, 8, 1'b0, 1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #2;
      if (err_fired) break;
    end
    check("err fired", {31'b0, err_fired}, 1);
    @(posedge clk);
    #1;
    check("err cyc", {31'b0, wbm_cyc_o}, 0);
    check("err stb", {31'b0, wbm_stb_o}, 0);
    check("err irq", {31'b0, stream_s_irq_o}, 1);
    check("err ready", {31'b0, stream_s_ready_o}, 0);
    check("err beats", beats.size(), 1);
    rd_check("err csr", 5'h00, 32'h6);
    tx_q.delete();
    wr(5'h00, 32'h2);

    // Reset mid-burst, then a fresh job
    start_job(32'h300, 32'd64, 32'd8, 16, 1'b1, -1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (wbm_cyc_o) break;
    end
    check("pre-reset cyc", {31'b0, wbm_cyc_o}, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst cyc", {31'b0, wbm_cyc_o}, 0);
    check("mid rst stb", {31'b0, wbm_stb_o}, 0);
    check("mid rst ready", {31'b0, stream_s_ready_o}, 0);
    tx_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rd_check("post rst csr", 5'h00, 32'h0);
    rd_check("post rst start", 5'h04, 32'h0);
    start_job(32'h400, 32'd16, 32'd4, 4, 1'b1, -1);
    wait_irq("post rst irq");
    check_job("post rst", 32'h400, 4, 4);
    rd_check("post rst done csr", 5'h00, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
